// File: rtl/wifi_reset_pkg.sv
// Shared definitions for the WiFi module reset sequencer: state codes,
// register map and status word layout.
package wifi_reset_pkg;

  typedef enum logic [1:0] {
    StInvalid = 2'd0,
    StPulse   = 2'd1,
    StBoot    = 2'd2,
    StReady   = 2'd3
  } seq_state_e;

  localparam logic [1:0] AddrCtrl  = 2'd0;
  localparam logic [1:0] AddrCount = 2'd1;
  localparam logic [1:0] AddrIrq   = 2'd2;
  localparam logic [1:0] AddrRsvd  = 2'd3;

  localparam int unsigned StatReadyBit   = 0;
  localparam int unsigned StatStateLsb   = 1;
  localparam int unsigned StatWifiRstBit = 3;
  localparam int unsigned IrqBit         = 0;
  localparam int unsigned TrigBit        = 0;

  function automatic logic [31:0] pack_status(input logic       wifi_rst_n,
                                              input seq_state_e st,
                                              input logic       ready);
    logic [31:0] s;
    s                       = '0;
    s[StatWifiRstBit]       = wifi_rst_n;
    s[StatStateLsb +: 2]    = st;
    s[StatReadyBit]         = ready;
    return s;
  endfunction

endpackage

// File: rtl/wifi_reset_sequencer_if.sv
// Avalon-MM slave register port of the WiFi reset sequencer.
interface wifi_reset_sequencer_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/wifi_rst_timer.sv
// Cycle timer: synchronous clear, increment up to a limit and hold there,
// terminal flag when the count has reached the limit.
module wifi_rst_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q < limit)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q >= limit);

endmodule

// File: rtl/wifi_reset_sequencer.sv
// WiFi module reset sequencer: drives a minimum-length reset pulse, waits for
// the module to boot, and reports status over an Avalon-MM register port.
module wifi_reset_sequencer
  import wifi_reset_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 500000,
  parameter int unsigned BOOT_CYCLES  = 25000000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  wifi_reset_sequencer_if.slave        bus,
  input  logic                         rst_req,
  output logic                         wifi_rst_n,
  output logic                         ready,
  output logic                         irq
);

  localparam logic [CNT_W-1:0] PulseLimit = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BootLimit  = CNT_W'(BOOT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic             rst_req_q;
  logic             wifi_rst_n_q;
  logic             ready_q;
  logic             irq_q, irq_d;
  logic [15:0]      pulse_count_q, pulse_count_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_done;

  logic             bus_wr;
  logic             sw_trig;
  logic             hw_trig;
  logic             trigger;
  logic             cnt_clr;
  logic             irq_clr;
  logic             pulse_done;
  logic             ready_entry;
  logic             unused_wdata;

  assign bus_wr  = bus.chipselect && !bus.write_n;
  assign sw_trig = bus_wr && (bus.address == AddrCtrl) && bus.writedata[TrigBit];
  assign hw_trig = rst_req && !rst_req_q;
  assign trigger = sw_trig || hw_trig;
  assign cnt_clr = bus_wr && (bus.address == AddrCount);
  assign irq_clr = bus_wr && (bus.address == AddrIrq) && bus.writedata[IrqBit];

  assign unused_wdata = ^bus.writedata[31:1];

  wifi_rst_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .limit   (tmr_limit),
    .done    (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    tmr_limit = PulseLimit;
    case (state_q)
      StPulse: begin
        tmr_en    = 1'b1;
        tmr_limit = PulseLimit;
        // A held request keeps the timer parked at its limit.
        if (trigger) begin
          tmr_clr = 1'b1;
        end else if (tmr_done && !rst_req) begin
          state_d = StBoot;
          tmr_clr = 1'b1;
        end
      end
      StBoot: begin
        tmr_en    = 1'b1;
        tmr_limit = BootLimit;
        if (trigger) begin
          state_d = StPulse;
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          state_d = StReady;
          tmr_clr = 1'b1;
        end
      end
      StReady: begin
        if (trigger) begin
          state_d = StPulse;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = StPulse;
        tmr_clr = 1'b1;
      end
    endcase
  end

  assign pulse_done  = (state_q == StPulse) && (state_d == StBoot);
  assign ready_entry = (state_q != StReady) && (state_d == StReady);

  always_comb begin
    pulse_count_d = pulse_count_q;
    if (cnt_clr) begin
      pulse_count_d = '0;
    end else if (pulse_done) begin
      pulse_count_d = pulse_count_q + 16'd1;
    end
  end

  always_comb begin
    irq_d = irq_q;
    if (ready_entry) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
  end

  // Pin registers load the decode of the next state so they always match state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StPulse;
      rst_req_q     <= 1'b0;
      wifi_rst_n_q  <= 1'b0;
      ready_q       <= 1'b0;
      irq_q         <= 1'b0;
      pulse_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rst_req_q     <= rst_req;
      wifi_rst_n_q  <= (state_d != StPulse);
      ready_q       <= (state_d == StReady);
      irq_q         <= irq_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  assign wifi_rst_n = wifi_rst_n_q;
  assign ready      = ready_q;
  assign irq        = irq_q;

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      AddrCtrl:  bus.readdata = pack_status(wifi_rst_n_q, state_q, ready_q);
      AddrCount: bus.readdata = {16'b0, pulse_count_q};
      AddrIrq:   bus.readdata = {31'b0, irq_q};
      AddrRsvd:  bus.readdata = '0;
      default:   bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_wifi_reset_sequencer.sv
// Directed scoreboard bench for wifi_reset_sequencer with short pulse/boot times.
module tb_wifi_reset_sequencer;

  localparam int unsigned PC = 4;
  localparam int unsigned BC = 8;

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic rst_req    = 1'b0;
  logic wifi_rst_n;
  logic ready;
  logic irq;

  wifi_reset_sequencer_if bus ();

  wifi_reset_sequencer #(
    .PULSE_CYCLES (PC),
    .BOOT_CYCLES  (BC),
    .CNT_W        (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .rst_req    (rst_req),
    .wifi_rst_n (wifi_rst_n),
    .ready      (ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];
  int          n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp_v = sb.pop_front();
      assert (obs === exp_v) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] d;
    push_exp(e);
    rd(a, d);
    check(tag, d);
  endtask

  task automatic chk_pin(input string tag, input logic obs, input logic e);
    push_exp({31'b0, e});
    check(tag, {31'b0, obs});
  endtask

  // Write lands on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  // Counts sampled cycles of wifi_rst_n low, starting with the current sample.
  task automatic wait_boot(output int cnt);
    cnt = 0;
    while (!wifi_rst_n && cnt < 50) begin
      cnt++;
      tick();
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (2) tick();

    chk_pin("rst_wifi", wifi_rst_n, 1'b0);
    chk_pin("rst_ready", ready, 1'b0);
    chk_pin("rst_irq", irq, 1'b0);
    chk_reg("rst_reg0", 2'd0, 32'h2);
    chk_reg("rst_reg1", 2'd1, 32'h0);
    chk_reg("rst_reg2", 2'd2, 32'h0);

    // Power-up sequence with no trigger.
    reset_n = 1'b1;
    push_exp(PC);
    wait_boot(n);
    check("pwrup_pulse_len", n);
    push_exp(BC);
    wait_ready(n);
    check("pwrup_boot_len", n);
    chk_pin("pwrup_irq", irq, 1'b1);
    chk_reg("pwrup_reg0", 2'd0, 32'hF);
    chk_reg("pwrup_count", 2'd1, 32'd1);
    chk_reg("pwrup_reg2", 2'd2, 32'd1);

    // Request held 10 clocks stretches the pulse.
    rst_req = 1'b1;
    tick();
    n = wifi_rst_n ? 0 : 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (!wifi_rst_n) n++;
    end
    push_exp(10);
    check("hold_low_len", n);
    rst_req = 1'b0;
    tick();
    chk_pin("hold_release", wifi_rst_n, 1'b1);
    push_exp(BC);
    wait_ready(n);
    check("hold_boot_len", n);
    chk_reg("hold_count", 2'd1, 32'd2);

    // One-clock request still yields the full minimum pulse.
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    push_exp(PC);
    wait_boot(n);
    check("short_pulse_len", n);
    push_exp(BC);
    wait_ready(n);
    check("short_boot_len", n);
    chk_reg("short_count", 2'd1, 32'd3);

    // Addr0 write without bit0 is not a trigger.
    wr(2'd0, 32'hFFFF_FFFE);
    chk_pin("notrig_ready", ready, 1'b1);

    // Software trigger mid-BOOT restarts pulse and boot.
    wr(2'd0, 32'h1);
    push_exp(PC);
    wait_boot(n);
    check("sw_pulse_len", n);
    repeat (5) tick();
    chk_reg("midboot_reg0", 2'd0, 32'hC);
    wr(2'd0, 32'h1);
    chk_pin("retrig_wifi", wifi_rst_n, 1'b0);
    chk_reg("retrig_reg0", 2'd0, 32'h2);
    push_exp(PC);
    wait_boot(n);
    check("retrig_pulse_len", n);
    push_exp(BC);
    wait_ready(n);
    check("retrig_boot_len", n);
    chk_reg("retrig_count", 2'd1, 32'd5);

    // irq clear, then set-vs-clear collision on READY entry.
    wr(2'd2, 32'h1);
    chk_pin("irq_clr", irq, 1'b0);
    wr(2'd0, 32'h1);
    push_exp(PC);
    wait_boot(n);
    check("irq_pulse_len", n);
    repeat (BC - 1) tick();
    chk_pin("pre_ready", ready, 1'b0);
    wr(2'd2, 32'h1);
    chk_pin("collide_ready", ready, 1'b1);
    chk_pin("collide_irq", irq, 1'b1);
    wr(2'd2, 32'h2);
    chk_reg("irq_bit1_noclr", 2'd2, 32'h1);
    wr(2'd2, 32'h1);
    chk_pin("irq_clr2", irq, 1'b0);

    // Count clear coinciding with PULSE->BOOT.
    wr(2'd0, 32'h1);
    repeat (PC - 1) tick();
    chk_pin("pre_boot_wifi", wifi_rst_n, 1'b0);
    wr(2'd1, 32'hDEAD_BEEF);
    chk_pin("collide_boot", wifi_rst_n, 1'b1);
    chk_reg("collide_count", 2'd1, 32'd0);
    push_exp(BC);
    wait_ready(n);
    check("collide_boot_len", n);
    chk_reg("collide_count2", 2'd1, 32'd0);
    wr(2'd3, 32'h1);
    chk_pin("addr3_ready", ready, 1'b1);
    chk_reg("addr3_read", 2'd3, 32'd0);

    // Reset mid-BOOT acts immediately.
    wr(2'd0, 32'h1);
    push_exp(PC);
    wait_boot(n);
    check("prerst_pulse_len", n);
    repeat (3) tick();
    chk_reg("prerst_count", 2'd1, 32'd1);
    chk_pin("prerst_irq", irq, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_pin("midboot_rst_wifi", wifi_rst_n, 1'b0);
    chk_pin("midboot_rst_ready", ready, 1'b0);
    chk_pin("midboot_rst_irq", irq, 1'b0);
    chk_reg("midboot_rst_reg0", 2'd0, 32'h2);
    chk_reg("midboot_rst_reg1", 2'd1, 32'h0);
    chk_reg("midboot_rst_reg2", 2'd2, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    push_exp(PC);
    wait_boot(n);
    check("repwr_pulse_len", n);
    push_exp(BC);
    wait_ready(n);
    check("repwr_boot_len", n);

    // Reset mid-READY.
    tick();
    reset_n = 1'b0;
    #1;
    chk_pin("midready_rst_wifi", wifi_rst_n, 1'b0);
    chk_pin("midready_rst_ready", ready, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wifi_reset_sequencer.md
WIFI_RESET_SEQUENCER -- requirements
Module: wifi_reset_sequencer

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 500000, minimum wifi_rst_n low time in clk cycles (10 ms at 50 MHz).
REQ-002 SHALL have parameter BOOT_CYCLES, default 25000000, module boot wait after release in clk cycles (500 ms at 50 MHz).
REQ-003 SHALL have parameter CNT_W, default 32, timer counter width; both cycle parameters SHALL be >=1 and < 2^CNT_W.
REQ-004 clk  input  1  system clock, sole clock domain.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  Avalon-MM select.
REQ-008 write_n  input  1  Avalon-MM active-low write strobe.
REQ-009 writedata  input  32  Avalon-MM write data.
REQ-010 readdata  output  32  Avalon-MM read data, zero wait states.
REQ-011 rst_req  input  1  reset request level from the upstream WiFi-reset PIO output (same clk domain).
REQ-012 wifi_rst_n  output  1  active-low reset pin to the WiFi module.
REQ-013 ready  output  1  high when the module has completed boot wait.
REQ-014 irq  output  1  sticky level interrupt, set on entry to READY.

Function
REQ-015 States SHALL be PULSE (2'd1), BOOT (2'd2), READY (2'd3); code 2'd0 SHALL transition to PULSE with timer cleared on the next clk.
REQ-016 A trigger SHALL be a rst_req rising edge (rst_req=1, registered previous value=0) or a write to address 0 with writedata[0]=1.
REQ-017 PULSE: wifi_rst_n=0; timer increments each clk; exit to BOOT with timer=0 when timer>=PULSE_CYCLES-1 and rst_req=0; while rst_req=1 the state SHALL remain PULSE with the timer saturated at PULSE_CYCLES-1.
REQ-018 BOOT: wifi_rst_n=1; timer increments; exit to READY when timer=BOOT_CYCLES-1; a trigger SHALL instead move to PULSE with timer=0.
REQ-019 READY: wifi_rst_n=1, ready=1; a trigger SHALL move to PULSE with timer=0.
REQ-020 A trigger during PULSE SHALL restart the timer at 0 (pulse extended, never shortened).
REQ-021 wifi_rst_n and ready SHALL be registered outputs, decoded from the registered state only.
REQ-022 pulse_count (16 bits) SHALL increment, wrapping at 0xFFFF, on each PULSE->BOOT transition.
REQ-023 Read map (combinational from address): 0 = {28'b0, wifi_rst_n, state[1:0], ready}; 1 = {16'b0, pulse_count}; 2 = {31'b0, irq}; 3 = 0.
REQ-024 Writes (chipselect=1, write_n=0): addr 0 bit0 = software trigger, self-clearing; addr 1 any value clears pulse_count; addr 2 bit0=1 clears irq; addr 3 ignored.
REQ-025 irq SHALL set on the clk where state becomes READY; set SHALL win over a simultaneous clear.
REQ-026 pulse_count increment and clear on the same clk SHALL result in 0.

Reset
REQ-027 reset_n low SHALL immediately force state=PULSE, timer=0, wifi_rst_n=0, ready=0, irq=0, pulse_count=0, rst_req history=0.
REQ-028 After reset_n deasserts, a full PULSE then BOOT sequence SHALL run without any trigger (power-up reset of the module).
REQ-029 Reset asserted mid-BOOT or mid-READY SHALL drive wifi_rst_n low asynchronously.

Structure
REQ-030 State codes, register addresses (0..3) and status bit positions SHALL live in shared package wifi_reset_pkg.
REQ-031 The cycle timer (clear, increment, saturate, terminal compare) SHALL be sub-module wifi_rst_timer; all else in the top module.

Verification (PULSE_CYCLES=4, BOOT_CYCLES=8)
REQ-032 Release reset_n, rst_req=0 -> wifi_rst_n low exactly 4 clks, high 8 clks later ready=1, irq=1, pulse_count=1.
REQ-033 In READY, rst_req high 10 clks then low -> wifi_rst_n low >=10 clks and until 4 clks elapsed, then BOOT, READY; pulse_count=2.
REQ-034 In BOOT at timer=5, write addr0=0x1 -> PULSE next clk, timer 0, full 4-clk pulse, BOOT restarts from 0.
REQ-035 READY entry and write addr2=0x1 on same clk -> irq stays 1; later write addr2=0x1 alone -> irq 0.
REQ-036 Assert reset_n mid-BOOT -> wifi_rst_n 0 same cycle, all reads return reset values (addr0 reads 0x2).
REQ-037 Write addr1 on the clk of a PULSE->BOOT transition -> pulse_count reads 0.
